// File: rtl/io_ctrl_pkg.sv
// Shared types, timing defaults and helpers for the IO-ring control blocks.
package io_ctrl_pkg;

   localparam int MAX_GROUPS             = 16;
   localparam int DEFAULT_N_GROUPS       = 4;
   localparam int DEFAULT_SETTLE_CYCLES  = 1024;
   localparam int DEFAULT_STAGGER_CYCLES = 16;

   typedef enum logic [2:0] {
      OFF,
      SETTLE,
      STAGGER,
      ACTIVE,
      UPDATE
   } io_seq_state_e;

   // Priority encoder: index of the lowest set bit, or -1 when the vector is empty.
   function automatic int lowest_set_index(input logic [MAX_GROUPS-1:0] vec);
      int idx;
      idx = -1;
      for (int i = MAX_GROUPS - 1; i >= 0; i--) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for slow level signals arriving from another domain.
module io_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Both stages clear on reset so the synchronized level starts deasserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_pad_oe_sequencer.sv
// Pad-ring output-enable sequencer: holds retention until VDDIO has settled, then
// enables pad groups one at a time so supply-pad switching current stays bounded.
module io_pad_oe_sequencer
   import io_ctrl_pkg::*;
#(
   parameter int N_GROUPS       = DEFAULT_N_GROUPS,
   parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
   parameter int STAGGER_CYCLES = DEFAULT_STAGGER_CYCLES,
   parameter int CNT_W          = $clog2((SETTLE_CYCLES > STAGGER_CYCLES) ?
                                         SETTLE_CYCLES : STAGGER_CYCLES) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vddio_ok_i,
   input  logic                en_i,
   input  logic [N_GROUPS-1:0] group_mask_i,
   input  logic                cfg_req_i,
   output logic                cfg_ack_o,
   output logic [N_GROUPS-1:0] pad_oe_grp_o,
   output logic                pad_ret_o,
   output logic                ready_o,
   output logic                fault_o
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

   io_seq_state_e       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_GROUPS-1:0] target_q, target_d;
   logic [N_GROUPS-1:0] oe_q, oe_d;
   logic [N_GROUPS-1:0] pending, first_bit;
   logic                ret_q, ret_d;
   logic                ready_q, ready_d;
   logic                ack_q, ack_d;
   logic                fault_q, fault_d;
   logic                upd_first_q, upd_first_d;
   logic                vddio_ok_s;
   int                  first_idx;

   io_sync2 u_vddio_sync (
      .clk (clk),
      .rst (rst),
      .d   (vddio_ok_i),
      .q   (vddio_ok_s)
   );

   assign pending = target_q & ~oe_q;

   // Next group to enable: lowest target bit that is not yet driving.
   always_comb begin
      first_idx = lowest_set_index(MAX_GROUPS'(pending));
      first_bit = '0;
      for (int g = 0; g < N_GROUPS; g++) begin
         if (g == first_idx) first_bit[g] = 1'b1;
      end
   end

   // Next-state and next-output logic; supply loss and disable override everything.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      target_d    = target_q;
      oe_d        = oe_q;
      ret_d       = ret_q;
      ready_d     = ready_q;
      ack_d       = 1'b0;
      fault_d     = fault_q;
      upd_first_d = 1'b0;

      if (state_q != OFF && (!vddio_ok_s || !en_i)) begin
         state_d = OFF;
         oe_d    = '0;
         ret_d   = 1'b1;
         ready_d = 1'b0;
         if (!vddio_ok_s && (state_q == STAGGER || state_q == ACTIVE || state_q == UPDATE))
            fault_d = 1'b1;
         else if (!en_i)
            fault_d = 1'b0;
      end else begin
         if (!en_i) fault_d = 1'b0;
         unique case (state_q)
            OFF: begin
               oe_d    = '0;
               ret_d   = 1'b1;
               ready_d = 1'b0;
               if (vddio_ok_s && en_i) begin
                  state_d = SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  target_d = group_mask_i;
                  ret_d    = 1'b0;
                  cnt_d    = STAGGER_LOAD;
                  state_d  = STAGGER;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            STAGGER, UPDATE: begin
               // Disables of an update all happen together before any new enable.
               if (state_q == UPDATE && upd_first_q) begin
                  oe_d  = oe_q & target_q;
                  cnt_d = STAGGER_LOAD;
               end else if (pending == '0) begin
                  state_d = ACTIVE;
                  ready_d = 1'b1;
                  ack_d   = (state_q == UPDATE);
               end else if (cnt_q == '0) begin
                  oe_d  = oe_q | first_bit;
                  cnt_d = STAGGER_LOAD;
                  if ((pending & ~first_bit) == '0) begin
                     state_d = ACTIVE;
                     ready_d = 1'b1;
                     ack_d   = (state_q == UPDATE);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ACTIVE: begin
               if (cfg_req_i) begin
                  target_d    = group_mask_i;
                  ready_d     = 1'b0;
                  state_d     = UPDATE;
                  upd_first_d = 1'b1;
               end
            end
            default: begin
               state_d = OFF;
            end
         endcase
      end
   end

   // All outputs come straight from these registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= OFF;
         cnt_q       <= '0;
         target_q    <= '0;
         oe_q        <= '0;
         ret_q       <= 1'b1;
         ready_q     <= 1'b0;
         ack_q       <= 1'b0;
         fault_q     <= 1'b0;
         upd_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         target_q    <= target_d;
         oe_q        <= oe_d;
         ret_q       <= ret_d;
         ready_q     <= ready_d;
         ack_q       <= ack_d;
         fault_q     <= fault_d;
         upd_first_q <= upd_first_d;
      end
   end

   assign pad_oe_grp_o = oe_q;
   assign pad_ret_o    = ret_q;
   assign ready_o      = ready_q;
   assign cfg_ack_o    = ack_q;
   assign fault_o      = fault_q;

endmodule

// File: tb/tb_io_pad_oe_sequencer.sv
// Bench for io_pad_oe_sequencer: scenario tasks with randomized masks, checked
// against a timeline model of when retention falls and each group rises.
module tb_io_pad_oe_sequencer;

   localparam int SETTLE  = 8;
   localparam int STAGGER = 4;
   localparam int NG      = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vddio_ok_i = 1'b1;
   logic          en_i = 1'b0;
   logic [NG-1:0] group_mask_i = '0;
   logic          cfg_req_i = 1'b0;
   logic          cfg_ack_o;
   logic [NG-1:0] pad_oe_grp_o;
   logic          pad_ret_o;
   logic          ready_o;
   logic          fault_o;

   logic [7:0]    obs;
   logic [NG-1:0] cur_mask = '0;
   int            tests_run = 0;
   int            tests_failed = 0;

   localparam logic [7:0] OFF_VEC   = 8'b0001_0000;
   localparam logic [7:0] FAULT_VEC = 8'b1001_0000;

   io_pad_oe_sequencer #(
      .N_GROUPS       (NG),
      .SETTLE_CYCLES  (SETTLE),
      .STAGGER_CYCLES (STAGGER)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vddio_ok_i   (vddio_ok_i),
      .en_i         (en_i),
      .group_mask_i (group_mask_i),
      .cfg_req_i    (cfg_req_i),
      .cfg_ack_o    (cfg_ack_o),
      .pad_oe_grp_o (pad_oe_grp_o),
      .pad_ret_o    (pad_ret_o),
      .ready_o      (ready_o),
      .fault_o      (fault_o)
   );

   always #5 clk = ~clk;

   // Observed vector layout: {fault, ack, ready, ret, oe[3:0]}.
   assign obs = {fault_o, cfg_ack_o, ready_o, pad_ret_o, pad_oe_grp_o};

   function automatic int count_bits(input logic [NG-1:0] v);
      int n;
      n = 0;
      for (int g = 0; g < NG; g++) if (v[g]) n++;
      return n;
   endfunction

   function automatic int ready_time(input logic [NG-1:0] m);
      int k;
      k = count_bits(m);
      return (k == 0) ? SETTLE + 1 : SETTLE + k * STAGGER;
   endfunction

   function automatic int upd_done(input logic [NG-1:0] old_m, input logic [NG-1:0] new_m);
      int k;
      k = count_bits(new_m & ~old_m);
      return (k == 0) ? 2 : 1 + k * STAGGER;
   endfunction

   // rel = cycles since the edge that accepted en_i; the k-th target group rises
   // k staggers after retention drops.
   function automatic logic [7:0] exp_power(input int rel, input logic [NG-1:0] m);
      logic [NG-1:0] oe;
      int            k;
      if (rel < 0) return OFF_VEC;
      oe = '0;
      k  = 0;
      for (int g = 0; g < NG; g++) begin
         if (m[g]) begin
            k++;
            if (rel >= SETTLE + k * STAGGER) oe[g] = 1'b1;
         end
      end
      return {1'b0, 1'b0, rel >= ready_time(m), rel < SETTLE, oe};
   endfunction

   // rel = cycles since the edge that accepted cfg_req_i.
   function automatic logic [7:0] exp_update(input int rel, input logic [NG-1:0] old_m,
                                             input logic [NG-1:0] new_m);
      logic [NG-1:0] oe;
      int            k;
      int            done;
      done = upd_done(old_m, new_m);
      if (rel == 0) return {4'b0000, old_m};
      oe = old_m & new_m;
      k  = 0;
      for (int g = 0; g < NG; g++) begin
         if (new_m[g] && !old_m[g]) begin
            k++;
            if (rel >= 1 + k * STAGGER) oe[g] = 1'b1;
         end
      end
      return {1'b0, rel == done, rel >= done, 1'b0, oe};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      en_i = 1'b1;
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (obs !== OFF_VEC) begin
         tests_failed++;
         $display("[TB] FAIL reset_async got=%b expected=%b", obs, OFF_VEC);
      end
      step();
      tests_run++;
      if (obs !== OFF_VEC) begin
         tests_failed++;
         $display("[TB] FAIL reset_hold got=%b expected=%b", obs, OFF_VEC);
      end
      rst  = 1'b0;
      en_i = 1'b0;
      step();
      tests_run++;
      if (obs !== OFF_VEC) begin
         tests_failed++;
         $display("[TB] FAIL reset_release got=%b expected=%b", obs, OFF_VEC);
      end
   endtask

   task automatic test_powerup(input logic [NG-1:0] m);
      logic [7:0] exp;
      en_i = 1'b0;
      step();
      step();
      en_i = 1'b1;
      group_mask_i = m;
      for (int c = 0; c <= SETTLE + NG * STAGGER + 2; c++) begin
         step();
         exp = exp_power(c, m);
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL powerup mask=%b c=%0d got=%b expected=%b", m, c, obs, exp);
         end
         if (c == SETTLE) group_mask_i = 4'($urandom);
      end
      cur_mask = m;
   endtask

   task automatic test_update(input logic [NG-1:0] new_m, input logic chain,
                              input logic [NG-1:0] next_m);
      logic [7:0] exp;
      int         done;
      int         last;
      done = upd_done(cur_mask, new_m);
      last = chain ? done : done + 2;
      cfg_req_i    = 1'b1;
      group_mask_i = new_m;
      for (int rel = 0; rel <= last; rel++) begin
         step();
         exp = exp_update(rel, cur_mask, new_m);
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL update %b->%b rel=%0d got=%b expected=%b",
                     cur_mask, new_m, rel, obs, exp);
         end
         if (rel == 0) group_mask_i = 4'($urandom);
         if (rel == done) begin
            if (chain) group_mask_i = next_m;
            else cfg_req_i = 1'b0;
         end
      end
      cur_mask = new_m;
   endtask

   task automatic test_back_to_back(input logic [NG-1:0] m1, input logic [NG-1:0] m2);
      test_update(m1, 1'b1, m2);
      test_update(m2, 1'b0, '0);
   endtask

   task automatic test_pending_req(input logic [NG-1:0] m0, input logic [NG-1:0] m1);
      logic [7:0] exp;
      int         rt;
      rt = ready_time(m0);
      en_i = 1'b0;
      step();
      step();
      en_i = 1'b1;
      group_mask_i = m0;
      for (int c = 0; c <= rt; c++) begin
         step();
         exp = exp_power(c, m0);
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL pending_req c=%0d got=%b expected=%b", c, obs, exp);
         end
         if (c == SETTLE) begin
            group_mask_i = m1;
            cfg_req_i    = 1'b1;
         end
      end
      cur_mask = m0;
      test_update(m1, 1'b0, '0);
   endtask

   task automatic test_supply_loss(input logic [NG-1:0] m);
      logic [7:0] exp;
      int         d;
      d = $urandom_range(SETTLE - 2, ready_time(m) - 3);
      en_i = 1'b0;
      step();
      step();
      en_i = 1'b1;
      group_mask_i = m;
      for (int c = 0; c <= d + 3; c++) begin
         step();
         exp = (c <= d + 2) ? exp_power(c, m) : FAULT_VEC;
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL supply_loss d=%0d c=%0d got=%b expected=%b", d, c, obs, exp);
         end
         if (c == d) vddio_ok_i = 1'b0;
      end
      vddio_ok_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         tests_run++;
         if (obs !== FAULT_VEC) begin
            tests_failed++;
            $display("[TB] FAIL fault_sticky i=%0d got=%b expected=%b", i, obs, FAULT_VEC);
         end
      end
      en_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++;
         if (obs !== OFF_VEC) begin
            tests_failed++;
            $display("[TB] FAIL fault_clear i=%0d got=%b expected=%b", i, obs, OFF_VEC);
         end
      end
   endtask

   // The FSM sees vddio_ok_i two edges late, so a glitch first sampled at edge g
   // lasting len edges lets settling restart at edge g+len+2.
   task automatic test_settle_glitch(input int g, input int len, input logic [NG-1:0] m);
      logic [7:0] exp;
      int         r;
      int         last;
      r    = g + len + 2;
      last = r + ready_time(m) + 1;
      en_i = 1'b0;
      step();
      step();
      en_i = 1'b1;
      group_mask_i = m;
      for (int c = 0; c <= last; c++) begin
         step();
         exp = (c < r) ? OFF_VEC : exp_power(c - r, m);
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL settle_glitch g=%0d len=%0d c=%0d got=%b expected=%b",
                     g, len, c, obs, exp);
         end
         if (c == g - 1) vddio_ok_i = 1'b0;
         if (c == g + len - 1) vddio_ok_i = 1'b1;
      end
      cur_mask = m;
   endtask

   task automatic test_disable_mid_update(input logic [NG-1:0] new_m);
      logic [7:0] exp;
      int         j;
      j = $urandom_range(0, upd_done(cur_mask, new_m) - 1);
      cfg_req_i    = 1'b1;
      group_mask_i = new_m;
      for (int rel = 0; rel <= j + 2; rel++) begin
         step();
         exp = (rel <= j) ? exp_update(rel, cur_mask, new_m) : OFF_VEC;
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL disable_mid_update j=%0d rel=%0d got=%b expected=%b",
                     j, rel, obs, exp);
         end
         if (rel == j) begin
            en_i      = 1'b0;
            cfg_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset(input logic [NG-1:0] new_m);
      logic [7:0] exp;
      cfg_req_i    = 1'b1;
      group_mask_i = new_m;
      for (int rel = 0; rel <= 1; rel++) begin
         step();
         exp = exp_update(rel, cur_mask, new_m);
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL reset_pre_update rel=%0d got=%b expected=%b", rel, obs, exp);
         end
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (obs !== OFF_VEC) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_update got=%b expected=%b", obs, OFF_VEC);
      end
      step();
      tests_run++;
      if (obs !== OFF_VEC) begin
         tests_failed++;
         $display("[TB] FAIL reset_no_ack got=%b expected=%b", obs, OFF_VEC);
      end
      rst       = 1'b0;
      cfg_req_i = 1'b0;
      en_i      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (obs !== OFF_VEC) begin
            tests_failed++;
            $display("[TB] FAIL reset_after i=%0d got=%b expected=%b", i, obs, OFF_VEC);
         end
      end
      test_powerup(4'b0000);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_powerup(4'b0101);
      test_update(4'b0110, 1'b0, '0);
      for (int i = 0; i < 4; i++) test_update(4'($urandom), 1'b0, '0);
      test_back_to_back(4'($urandom), 4'($urandom));
      for (int i = 0; i < 3; i++) test_powerup(4'($urandom));
      test_pending_req(4'($urandom), 4'($urandom));
      test_supply_loss(4'($urandom_range(1, 15)));
      test_settle_glitch(5, 3, 4'b0101);
      test_settle_glitch(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 4'($urandom));
      test_powerup(4'($urandom));
      test_disable_mid_update(4'($urandom));
      test_powerup(4'b1111);
      test_async_reset(4'($urandom));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
